// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch unit. Requests a word from instruction
//                memory, holds it for the decoder until it is retired, then
//                advances the PC (sequential, jump, register jump, branch).
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        is_jump,
    input  logic        is_branch,
    input  logic        jump_reg,
    input  logic        branch_taken,
    input  logic [25:0] addr26,
    input  logic [15:0] imm16,
    input  logic [31:0] jr_target,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] c_PC_STEP = 32'd4;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic [31:0] r_instr_count;
    logic        r_mem_req;
    logic        r_instr_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_next_pc;
    logic        w_unused;

    assign w_pc_plus4   = r_pc + c_PC_STEP;
    assign w_branch_off = {{14{imm16[15]}}, imm16, 2'b00};
    // Register jumps force word alignment, so the low target bits are dropped.
    assign w_unused     = ^jr_target[1:0];

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump_reg) begin
            w_next_pc = {jr_target[31:2], 2'b00};
        end else if (is_jump) begin
            w_next_pc = {w_pc_plus4[31:28], addr26, 2'b00};
        end else if (is_branch && branch_taken) begin
            w_next_pc = w_pc_plus4 + w_branch_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instruction <= 32'h0;
            r_instr_count <= 32'h0;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state   <= S_FETCH;
                    r_mem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_instruction <= mem_rdata;
                        r_state       <= S_HOLD;
                        r_mem_req     <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Redirect controls only matter on the retire edge.
                    if (instr_ready) begin
                        r_pc          <= w_next_pc;
                        r_instr_count <= r_instr_count + 32'd1;
                        r_state       <= S_FETCH;
                        r_mem_req     <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_mem_req     <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_pc;
    assign instruction = r_instruction;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch with a fetch scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req, mem_ack, instr_valid, instr_ready;
    logic [31:0] mem_addr, mem_rdata, instruction, pc, pc_plus4, instr_count;
    logic        is_jump, is_branch, jump_reg, branch_taken;
    logic [25:0] addr26;
    logic [15:0] imm16;
    logic [31:0] jr_target;

    logic        mem_req2, instr_valid2;
    logic [31:0] mem_addr2, instruction2, pc2, pc_plus4_2, instr_count2;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(instruction),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
        .pc_plus4(pc_plus4), .is_jump(is_jump), .is_branch(is_branch),
        .jump_reg(jump_reg), .branch_taken(branch_taken), .addr26(addr26),
        .imm16(imm16), .jr_target(jr_target), .instr_count(instr_count)
    );

    // Zero-wait memory and an always-ready consumer, starting at the top of memory.
    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ack(mem_req2), .mem_rdata(32'hDEAD_BEEF), .instruction(instruction2),
        .instr_valid(instr_valid2), .instr_ready(1'b1), .pc(pc2),
        .pc_plus4(pc_plus4_2), .is_jump(1'b0), .is_branch(1'b0),
        .jump_reg(1'b0), .branch_taken(1'b0), .addr26(26'h0),
        .imm16(16'h0), .jr_target(32'h0), .instr_count(instr_count2)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic j,
                                               input logic jr, input logic br, input logic bt,
                                               input logic [25:0] a26, input logic [15:0] i16,
                                               input logic [31:0] jrt);
        logic [31:0] p4;
        p4 = cur + 32'd4;
        if (jr)             return {jrt[31:2], 2'b00};
        else if (j)         return {p4[31:28], a26, 2'b00};
        else if (br && bt)  return p4 + {{14{i16[15]}}, i16, 2'b00};
        else                return p4;
    endfunction

    task automatic randomize_redirect();
        is_jump      = 1'($urandom_range(0, 1));
        is_branch    = 1'($urandom_range(0, 1));
        jump_reg     = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
        addr26       = 26'($urandom);
        imm16        = 16'($urandom);
        jr_target    = $urandom;
    endtask

    // Entered at a falling edge with the DUT in FETCH; leaves it in FETCH again.
    task automatic do_instr(input logic [31:0] rdata, input int ack_dly, input int rdy_dly,
                            input logic j, input logic jr, input logic br, input logic bt,
                            input logic [25:0] a26, input logic [15:0] i16,
                            input logic [31:0] jrt);
        exp_t        e;
        exp_t        got;
        logic [31:0] nxt;
        e.pc    = exp_pc;
        e.instr = rdata;
        sb.push_back(e);
        for (int i = 0; i < ack_dly; i++) begin
            mem_ack = 1'b0;
            chk("wait_req", 32'(mem_req), 32'd1);
            chk("wait_addr", mem_addr, exp_pc);
            chk("wait_valid", 32'(instr_valid), 32'd0);
            @(negedge clk);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        chk("ack_req", 32'(mem_req), 32'd1);
        chk("ack_addr", mem_addr, exp_pc);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_req", 32'(mem_req), 32'd0);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
            got = e;
        end else begin
            got = sb.pop_front();
        end
        chk("instr", instruction, got.instr);
        chk("pc", pc, got.pc);
        chk("pc_plus4", pc_plus4, got.pc + 32'd4);
        for (int i = 0; i < rdy_dly; i++) begin
            instr_ready = 1'b0;
            mem_ack     = 1'($urandom_range(0, 1));
            mem_rdata   = $urandom;
            randomize_redirect();
            @(negedge clk);
            chk("stall_instr", instruction, got.instr);
            chk("stall_pc", pc, got.pc);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_req", 32'(mem_req), 32'd0);
            chk("stall_count", instr_count, exp_count);
        end
        mem_ack      = 1'b0;
        instr_ready  = 1'b1;
        is_jump      = j;
        jump_reg     = jr;
        is_branch    = br;
        branch_taken = bt;
        addr26       = a26;
        imm16        = i16;
        jr_target    = jrt;
        nxt = model_next(exp_pc, j, jr, br, bt, a26, i16, jrt);
        @(negedge clk);
        instr_ready = 1'b0;
        randomize_redirect();
        exp_pc    = nxt;
        exp_count = exp_count + 32'd1;
        chk("retire_count", instr_count, exp_count);
        chk("retire_valid", 32'(instr_valid), 32'd0);
        chk("retire_req", 32'(mem_req), 32'd1);
        chk("retire_addr", mem_addr, exp_pc);
    endtask

    task automatic chk_reset_state();
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_count", instr_count, 32'h0);
    endtask

    initial begin
        mem_ack = 1'b0; mem_rdata = 32'h0; instr_ready = 1'b0;
        is_jump = 1'b0; is_branch = 1'b0; jump_reg = 1'b0; branch_taken = 1'b0;
        addr26 = 26'h0; imm16 = 16'h0; jr_target = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        chk_reset_state();
        chk("wrap_rst_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_rst_pc_plus4", pc_plus4_2, 32'h0);
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        exp_pc    = 32'h0;
        exp_count = 32'h0;
        chk("first_req", 32'(mem_req), 32'd1);

        do_instr(32'h2010FEFE, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 16'h0, 32'h0);
        chk("first_next_addr", mem_addr, 32'h4);
        chk("first_count", instr_count, 32'd1);
        chk("wrap_pc", pc2, 32'h0);
        chk("wrap_count", instr_count2, 32'd1);

        do_instr($urandom, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 16'h0, 32'h0);
        do_instr($urandom, 0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 16'h0, 32'h0);
        do_instr($urandom, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 16'h0, 32'h0);
        chk("at_0x10", pc, 32'h10);
        do_instr($urandom, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 26'h4, 16'h0, 32'h0);
        chk("jump_tgt", mem_addr, 32'h10);
        do_instr($urandom, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 26'h3FF_FFFF, 16'h0, 32'h103);
        chk("jr_tgt", mem_addr, 32'h100);
        do_instr($urandom, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 26'h8, 16'h0, 32'h0);
        chk("at_0x20", pc, 32'h20);
        do_instr($urandom, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 26'h0, 16'hFFFC, 32'h0);
        chk("branch_taken", pc, 32'h14);
        do_instr($urandom, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 26'h8, 16'h0, 32'h0);
        do_instr($urandom, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0, 16'hFFFC, 32'h0);
        chk("branch_not_taken", pc, 32'h24);

        for (int k = 0; k < 8; k++) begin
            do_instr($urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     26'($urandom), 16'($urandom), $urandom);
        end

        // Back-to-back: zero-wait ack and ready held high, one retire per 2 cycles.
        is_jump = 1'b0; is_branch = 1'b0; jump_reg = 1'b0; branch_taken = 1'b0;
        mem_ack = 1'b1; instr_ready = 1'b1; mem_rdata = $urandom;
        repeat (10) @(negedge clk);
        mem_ack = 1'b0; instr_ready = 1'b0;
        exp_count = exp_count + 32'd5;
        exp_pc    = exp_pc + 32'd20;
        chk("tput_count", instr_count, exp_count);
        chk("tput_addr", mem_addr, exp_pc);
        chk("tput_req", 32'(mem_req), 32'd1);

        // Reset in the middle of a fetch, ack pulsed while still idle.
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("post_rst_instr", instruction, 32'h0);
        chk("post_rst_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_req", 32'(mem_req), 32'd1);
        chk("post_rst_addr", mem_addr, 32'h0);
        exp_pc    = 32'h0;
        exp_count = 32'h0;
        do_instr(32'h1234_5678, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 16'h0, 32'h0);
        chk("restart_addr", mem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 mem_req  output  1  instruction-memory read request, held high until acknowledged.
REQ-005 mem_addr  output  32  byte address of the word being fetched; equals pc.
REQ-006 mem_ack  input  1  memory has returned mem_rdata this cycle.
REQ-007 mem_rdata  input  32  instruction word, valid only when mem_ack=1.
REQ-008 instruction  output  32  registered instruction word presented to the control decoder.
REQ-009 instr_valid  output  1  instruction/pc outputs hold a fetched word not yet consumed.
REQ-010 instr_ready  input  1  datapath consumes the presented instruction this cycle.
REQ-011 pc  output  32  address of the current instruction.
REQ-012 pc_plus4  output  32  pc+4, modulo 2^32.
REQ-013 is_jump, is_branch, jump_reg, branch_taken  input  1 each  decoder/datapath redirect controls for the presented instruction.
REQ-014 addr26  input  26  jump target field; imm16  input  16  branch offset field; jr_target  input  32  register jump target.
REQ-015 instr_count  output  32  number of instructions retired.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, HOLD.
REQ-017 IDLE: entered on reset; SHALL move to FETCH on the first clock edge with rst_n high.
REQ-018 FETCH: mem_req=1, mem_addr=pc, stable until an edge where mem_ack=1; on that edge instruction<=mem_rdata, state->HOLD.
REQ-019 mem_ack SHALL be ignored in IDLE and HOLD (no capture, no state change).
REQ-020 HOLD: instr_valid=1, instruction and pc stable; mem_req=0; stays until an edge with instr_ready=1 (retire).
REQ-021 On retire, pc SHALL update to next_pc, instr_count SHALL increment (wrapping at 2^32), state->FETCH.
REQ-022 next_pc priority: jump_reg=1 -> {jr_target[31:2],2'b00}; else is_jump=1 -> {pc_plus4[31:28],addr26,2'b00}; else is_branch=1 and branch_taken=1 -> pc_plus4 + (sign_extend(imm16)<<2); else pc_plus4.
REQ-023 Redirect inputs SHALL be sampled only on the retire edge; other values are don't-care.
REQ-024 All 32-bit address arithmetic SHALL wrap modulo 2^32 (pc=32'hFFFF_FFFC -> pc_plus4=32'h0).
REQ-025 Throughput: zero-wait memory (ack in the request cycle) and instr_ready tied high SHALL yield one retire every 2 cycles.
REQ-026 instr_valid SHALL be 0 in IDLE and FETCH; mem_req SHALL be 0 in IDLE and HOLD.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, pc=RESET_PC, instruction=32'h0, instr_valid=0, mem_req=0, instr_count=0; pc_plus4=RESET_PC+4.
REQ-028 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the transaction; a mem_ack arriving after reset release but before FETCH is re-entered SHALL be ignored.

Verification
REQ-029 Reset release, ack in same cycle as req, rdata=32'h2010FEFE, ready=1 -> mem_addr=0, instruction=32'h2010FEFE valid one cycle later, next mem_addr=4, instr_count=1.
REQ-030 Ack delayed 3 cycles -> mem_req and mem_addr=pc held constant all 3 cycles, instr_valid low until after ack edge.
REQ-031 pc=32'h0000_0010, retire with is_jump=1, addr26=26'h4 -> next mem_addr=32'h0000_0010; with jump_reg=1 also set, jr_target=32'h0000_0103 -> next mem_addr=32'h0000_0100.
REQ-032 pc=32'h0000_0020, is_branch=1, imm16=16'hFFFC: branch_taken=1 -> next pc=32'h0000_0014; branch_taken=0 -> next pc=32'h0000_0024.
REQ-033 instr_ready low for 5 cycles in HOLD -> instruction, pc, instr_valid stable, mem_req=0, instr_count unchanged; RESET_PC=32'hFFFF_FFFC sequential retire -> pc wraps to 32'h0.
REQ-034 rst_n pulsed low mid-FETCH, then mem_ack pulsed in IDLE -> outputs at reset values, ack ignored, fetch restarts at RESET_PC.
